// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words with auto-incrementing write address.
// Optional immediate range/alignment checking is enabled by defining INSTR_ENC_IMM_CHECK_EN.
package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_I_TYPE = 7'b0010011,
    OP_R_TYPE = 7'b0110011
  } opcode_t;
endpackage

module instr_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  opcode_t         in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_addr,
  output logic            out_err,
  output logic [7:0]      err_count
);

  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'((DEPTH - 1) * 4);

  logic            vld_p1;
  logic [XLEN-1:0] instr_p1;
  logic [XLEN-1:0] addr_p1;
  logic            err_p1;
  logic [7:0]      err_cnt;
  logic [32:0]     enc_p0;
  logic            accept;
  logic            out_hs;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a);
    return (a == LAST_ADDR) ? BASE_ADDR : a + 32'd4;
  endfunction

  // Returns {err, instr}; unencodable requests collapse to a NOP word.
  function automatic logic [32:0] encode(
    input opcode_t     op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic        bad;
    w   = '0;
    bad = 1'b0;
    case (op)
      OP_R_TYPE: w = {f7, rs2, rs1, f3, rd, 7'(op)};
      OP_I_TYPE, OP_LOAD, OP_JALR: begin
        w = {imm[11:0], rs1, f3, rd, 7'(op)};
`ifdef INSTR_ENC_IMM_CHECK_EN
        bad = (imm[31:11] != {21{imm[31]}});
`endif
      end
      OP_STORE: begin
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'(op)};
`ifdef INSTR_ENC_IMM_CHECK_EN
        bad = (imm[31:11] != {21{imm[31]}});
`endif
      end
      OP_BRANCH: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'(op)};
`ifdef INSTR_ENC_IMM_CHECK_EN
        bad = (imm[31:12] != {20{imm[31]}}) || imm[0];
`endif
      end
      OP_JAL: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'(op)};
`ifdef INSTR_ENC_IMM_CHECK_EN
        bad = (imm[31:20] != {12{imm[31]}}) || imm[0];
`endif
      end
      OP_LUI, OP_AUIPC: begin
        w = {imm[31:12], rd, 7'(op)};
`ifdef INSTR_ENC_IMM_CHECK_EN
        bad = (imm[11:0] != 12'd0);
`endif
      end
      default: bad = 1'b1;
    endcase
    return bad ? {1'b1, NOP_WORD} : {1'b0, w};
  endfunction

`ifndef INSTR_ENC_IMM_CHECK_EN
  logic unused_imm_lsb;
  assign unused_imm_lsb = in_imm[0];
`endif

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready && !clear;
  assign out_hs   = vld_p1 && out_ready;

  // Stage p0 -> p1: encode and capture into the one-entry output register.
  assign enc_p0 = encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      addr_p1  <= BASE_ADDR;
      err_p1   <= 1'b0;
      err_cnt  <= '0;
    end else if (clear) begin
      vld_p1  <= 1'b0;
      addr_p1 <= BASE_ADDR;
      err_cnt <= '0;
    end else begin
      if (out_hs) begin
        addr_p1 <= next_addr(addr_p1);
        if (err_p1) err_cnt <= sat_inc(err_cnt);
      end
      if (accept) begin
        vld_p1   <= 1'b1;
        instr_p1 <= enc_p0[31:0];
        err_p1   <= enc_p0[32];
      end else if (out_hs) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_instr = instr_p1;
  assign out_addr  = addr_p1;
  assign out_err   = err_p1;
  assign err_count = err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4 so address wrap is reachable).
module tb_instr_encoder;
  import riscv_pkg::*;

`ifdef INSTR_ENC_IMM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  opcode_t     in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input opcode_t op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm);
    in_valid  = v;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] instr,
                         input logic [31:0] addr, input logic err);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".instr"}, out_instr, instr);
    chk({tag, ".addr"},  out_addr,  addr);
    chk({tag, ".err"},   {31'd0, out_err}, {31'd0, err});
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    req(1'b0, OP_I_TYPE, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #2;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk_out("rst", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst.err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // addi x1,x0,5 with one-cycle latency
    req(1'b1, OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    chk_out("addi", 1'b1, 32'h0050_0093, 32'h0, 1'b0);

    // clear so the stream starts at address 0
    out_ready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr1.valid", {31'd0, out_valid}, 32'd0);
    chk("clr1.addr", out_addr, 32'h0);

    // sw, beq, jal back-to-back
    req(1'b1, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    chk_out("sw", 1'b1, 32'h0020_A423, 32'h0, 1'b0);
    req(1'b1, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    tick();
    chk_out("beq", 1'b1, 32'hFE00_0EE3, 32'h4, 1'b0);
    req(1'b1, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    chk_out("jal", 1'b1, 32'h0010_00EF, 32'h8, 1'b0);

    // backpressure: jal held, addi x3,x0,-1 waits
    out_ready = 1'b0;
    req(1'b1, OP_I_TYPE, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    #1;
    chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 1'b1, 32'h0010_00EF, 32'h8, 1'b0);
      chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("release", 1'b1, 32'hFFF0_0193, 32'hC, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("wrap.valid", {31'd0, out_valid}, 32'd0);
    chk("wrap.addr", out_addr, 32'h0);

    // addi x1,x0,2048: out of range only when checks are enabled
    req(1'b1, OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    in_valid = 1'b0;
    chk_out("addi2048", 1'b1, CHK ? 32'h0000_0013 : 32'h8000_0093, 32'h0, CHK);
    tick();
    chk("addi2048.err_count", {24'd0, err_count}, CHK ? 32'd1 : 32'd0);
    chk("addi2048.addr", out_addr, 32'h4);

    // unsupported opcode always errors
    req(1'b1, opcode_t'(7'h7F), 5'd1, 5'd2, 5'd3, 3'd1, 7'd5, 32'd0);
    tick();
    in_valid = 1'b0;
    chk_out("badop", 1'b1, 32'h0000_0013, 32'h4, 1'b1);
    tick();
    chk("badop.err_count", {24'd0, err_count}, CHK ? 32'd2 : 32'd1);

    // lui and R-type sub streamed into addresses 8 and C, then wrap
    req(1'b1, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    tick();
    chk_out("lui", 1'b1, 32'h1234_52B7, 32'h8, 1'b0);
    req(1'b1, OP_R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    tick();
    chk_out("sub", 1'b1, 32'h4020_81B3, 32'hC, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("wrap2.addr", out_addr, 32'h0);

    // clear wins over a handshake and a new request in the same cycle
    out_ready = 1'b0;
    req(1'b1, OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    out_ready = 1'b1;
    clear = 1'b1;
    #1;
    chk("clr2.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr2.valid", {31'd0, out_valid}, 32'd0);
    chk("clr2.addr", out_addr, 32'h0);
    chk("clr2.err_count", {24'd0, err_count}, 32'd0);

    // asynchronous reset while a word is held
    req(1'b1, OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    req(1'b1, OP_I_TYPE, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk_out("pre_rst", 1'b1, 32'h0070_0113, 32'h4, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    req(1'b1, OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    chk_out("post_rst", 1'b1, 32'h0050_0093, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder, the inverse of the immediate generator. It accepts decoded instruction fields (opcode, registers, funct codes, 32-bit immediate) on a valid/ready interface. It packs them into 32-bit instruction words, scattering the immediate per I/S/B/J/U format, and emits each word with an auto-incrementing instruction-memory write address through a one-entry output pipeline register. It feeds the test/debug program loader into instruction memory.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: first write address after reset or clear; word-aligned.
- `DEPTH`, default 1024: number of instruction words in the target memory; address wraps after DEPTH words.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  sync: reset address to BASE_ADDR, drop held output, zero err_count.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when in_valid && in_ready.
- `in_opcode`  in  opcode_t  riscv_pkg opcode.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3  funct3.
- `in_funct7`  in  7  funct7, used for OP_R_TYPE only.
- `in_imm`  in  XLEN  immediate as a signed byte offset/value; U-type carries the full 32-bit value.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts when out_valid && out_ready.
- `out_instr`  out  XLEN  encoded instruction.
- `out_addr`  out  XLEN  byte address for out_instr.
- `out_err`  out  1  request was not encodable; out_instr is NOP.
- `err_count`  out  8  saturating count of emitted errored words.

## Operation
- Field placement: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25]; fields not used by a format are zero.
- R (OP_R_TYPE): funct7, rs2, rs1, funct3, rd.
- I (OP_I_TYPE, OP_LOAD, OP_JALR): imm[11:0]→[31:20]. Shift encodings are supplied in imm, e.g. srai uses 0x400|shamt.
- S (OP_STORE): imm[11:5]→[31:25], imm[4:0]→[11:7].
- B (OP_BRANCH): imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7.
- J (OP_JAL): imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12].
- U (OP_LUI, OP_AUIPC): imm[31:12]→[31:12].
- Any other opcode: out_err=1, out_instr=32'h0000_0013 (NOP). This holds regardless of configuration.
- Address: out_addr starts at BASE_ADDR and advances by 4 on every output handshake, errored words included. After BASE_ADDR+4*(DEPTH-1) it wraps to BASE_ADDR.
- err_count increments on each output handshake with out_err=1 and saturates at 255.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_count=0.
- Latency: 1 cycle. A request accepted at edge N shows out_valid=1 after edge N.
- in_ready = !out_valid || out_ready (combinational). Throughput is 1 word/cycle under continuous out_ready.
- While out_valid && !out_ready: out_instr, out_addr and out_err are held stable and no new request is accepted.
- Simultaneous output handshake and new request: the register reloads in the same edge with no bubble, and the address advances once.
- clear has priority over the handshakes in its cycle. Next cycle: out_valid=0, address=BASE_ADDR, err_count=0. A request presented in a clear cycle is dropped, but in_ready still reflects the formula above.
- rst_n assertion mid-stream aborts the held word immediately (asynchronous) and returns all outputs to reset values.

## Configuration
- `INSTR_ENC_IMM_CHECK_EN` defined: range/alignment checks apply, and a failure yields out_err=1 with a NOP word.
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
- Undefined: no immediate checks; out-of-range bits are silently truncated. out_err is raised only for unsupported opcodes.

## Test plan
- addi x1,x0,5 (I_TYPE, rd=1, funct3=0, imm=5) → out_instr 0x00500093, out_addr BASE_ADDR, out_err=0, one cycle after accept.
- sw x2,8(x1) then beq x0,x0,-4 then jal x1,2048 streamed back-to-back with out_ready=1 → 0x0020A423, 0xFE000EE3, 0x001000EF at addresses 0,4,8, with no bubbles.
- out_ready held low 3 cycles with a word pending → in_ready=0 and outputs stable; on release the word is accepted and the next request enters the same cycle.
- addi x1,x0,2048: with the macro → out_err=1, out_instr 0x00000013, err_count=1; without the macro → out_instr 0x80000093, out_err=0.
- DEPTH=4, BASE_ADDR=0, five words → addresses 0x0,0x4,0x8,0xC,0x0. Then pulse clear → next word at 0x0 and err_count=0.
- rst_n low for one cycle while out_valid=1 and out_ready=0 → out_valid=0 immediately and all outputs at reset values; the first word after release goes to BASE_ADDR.
